conv_stream_engine: RTL and testbench
=====================================

Name: conv_stream_engine

Overview:
- Parametrised streaming 2-D convolution engine; successor to the host-stepped 3-tap conv datapath in the NPU.
- Accepts a raster-order pixel stream over valid/ready. Builds the KxK window internally with line buffers and computes one full KxK dot product per accepted window position; the host no longer steps each row.
- Optional bias and ReLU per frame.
- Sits between the NPU host register interface (weight/bias writes, start, done) and the pack/FCN stage, which consumes its output stream.

Parameters:
- K, 3, kernel height and width (square, K>=2).
- IMG_W, 15, frame width in pixels.
- IMG_H, 16, frame height in pixels.
- DW, 8, pixel and weight width. Pixels are unsigned; weights are signed.
- ACC_W, 24, accumulator/output width, signed. Elaboration-time assertion: ACC_W >= 2*DW+1+clog2(K*K).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse; begins a frame (accepted only in S_IDLE)
- relu_en  in  1  sampled at start; clamp negative results to 0
- w_we  in  1  weight/bias write strobe
- w_addr  in  clog2(K*K+1)  0..K*K-1 = weight, row-major; K*K = bias
- w_data  in  ACC_W  weights use [DW-1:0] signed; bias uses the full width
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_data  in  DW  unsigned pixel
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  ACC_W  signed result
- out_last  out  1  high with the final result of the frame
- busy  out  1  high in S_RUN and S_DRAIN
- done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset values:
  - state = S_IDLE.
  - in_ready, out_valid, out_last, busy, done = 0.
  - out_data = 0.
  - All weights, bias and line-buffer contents = 0.
  - Counters = 0; relu mode = 0.
- FSM:
  - S_IDLE: in_ready=0. Weight/bias writes take effect. start -> S_RUN, clear row/col/output counters, latch relu_en.
  - S_RUN: in_ready = !stall. Each accepted pixel advances col, wrapping at IMG_W-1 and incrementing row. The acceptance of pixel (IMG_H-1, IMG_W-1) -> S_DRAIN.
  - S_DRAIN: in_ready=0. When the pipeline is empty and the last result has been accepted downstream -> S_IDLE, with done=1 for that one cycle.
- start outside S_IDLE is ignored.
- w_we outside S_IDLE is ignored; weights are stable for a whole frame.
- w_we and start in the same S_IDLE cycle: the write is applied and start is accepted.
- Window:
  - K-1 line buffers of IMG_W entries plus a KxK shift window.
  - A window is valid on acceptance of pixel (r,c) with r>=K-1 and c>=K-1.
  - That result corresponds to output position (r-K+1, c-K+1).
  - Total outputs per frame: (IMG_H-K+1)*(IMG_W-K+1), which is 182 at defaults.
- Pipeline, 2 stages:
  - Stage 1: K*K products, pixel zero-extended to DW+1 signed x weight, registered.
  - Stage 2: adder tree + bias, then ReLU if latched; the result is registered into out_data.
  - Latency: out_valid rises 2 cycles after the accepting edge of the window-completing pixel.
- Backpressure:
  - stall = out_valid && !out_ready.
  - On stall, the whole pipeline and window freeze and in_ready=0.
  - out_data is held stable while out_valid && !out_ready.
- out_last is asserted with result number (outputs-1). It is cleared when that result is accepted.
- Arithmetic: sums are exact in ACC_W with no saturation. ReLU applies after the bias is added.
- Line buffers are not cleared between frames. Only positions with r>=K-1 and c>=K-1 are emitted, so stale data is never used.
- Reset mid-frame returns everything to reset values immediately, and any partial output is dropped. Weights are also cleared, so the host must reload them.

Decomposition:
- npu_pkg holds:
  - the state_e enum {S_IDLE, S_RUN, S_DRAIN};
  - the weight-address constant BIAS_ADDR = K*K;
  - the function acc_min_width(DW, K) used by the assertion.
- Sub-module window_line_buffer (params K, IMG_W, DW): shift enable in, pixel in, KxK window out.
- The MAC tree, FSM and output register stay in conv_stream_engine.

Test Plan:
- Identity frame: all weights 1, bias 0, relu 0, all pixels 1 -> 182 outputs of 9; out_last on the 182nd; done pulses once.
- Centre tap: weight[4]=1, all others 0, pixel(r,c)=(r*IMG_W+c)&255 -> output n at (i,j) equals pixel(i+1,j+1).
- Sign/ReLU: all weights -128, pixels 255, bias 0:
  - relu 0 -> every output is -293760;
  - relu 1 -> every output is 0.
  - Bias 100 with weights 1 and pixels 1 -> 109.
- Backpressure: out_ready random at 30% duty, in_valid random -> in_ready is low whenever out_valid && !out_ready; out_data is stable while stalled; the output sequence is identical to the no-stall run.
- Control corners:
  - start during S_RUN is ignored;
  - w_we during S_RUN is ignored, and the next frame uses the old weights;
  - w_we and start in the same cycle -> the new weight is used.
- Reset at pixel 100 of a frame -> all outputs return to reset values within the same cycle; a fresh weight load and start yield a correct full 182-result frame.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU streaming convolution engine.
package npu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int unsigned K_DEFAULT = 3;
  // Weight addresses 0..K*K-1 are taps in row-major order; the next address is the bias.
  localparam int unsigned BIAS_ADDR = K_DEFAULT * K_DEFAULT;

  // Minimum signed accumulator width for K*K products of an unsigned DW pixel and a signed DW weight.
  function automatic int unsigned acc_min_width(input int unsigned dw, input int unsigned k);
    return 2 * dw + 1 + $clog2(k * k);
  endfunction

endpackage

// File: rtl/window_line_buffer.sv
// K-1 line buffers plus a KxK shift window over a raster pixel stream.
// Window row 0 is the oldest line; column K-1 is the most recent pixel.
module window_line_buffer #(
  parameter int unsigned K     = 3,
  parameter int unsigned IMG_W = 15,
  parameter int unsigned DW    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_en_i,
  input  logic [$clog2(IMG_W)-1:0]      col_i,
  input  logic [DW-1:0]                 pix_i,
  output logic [K*K-1:0][DW-1:0]        win_o
);

  logic [DW-1:0] lb_q  [K-1][IMG_W];
  logic [DW-1:0] win_q [K][K];
  logic [DW-1:0] colv  [K];

  // Incoming column: line buffer K-2 holds the oldest row, the live pixel is the newest.
  always_comb begin
    for (int i = 0; i < K; i++) colv[i] = '0;
    for (int i = 0; i < K - 1; i++) colv[i] = lb_q[K-2-i][col_i];
    colv[K-1] = pix_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < K - 1; a++)
        for (int b = 0; b < IMG_W; b++) lb_q[a][b] <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win_q[i][j] <= '0;
    end else if (shift_en_i) begin
      lb_q[0][col_i] <= pix_i;
      for (int a = 1; a < K - 1; a++) lb_q[a][col_i] <= lb_q[a-1][col_i];
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win_q[i][j] <= win_q[i][j+1];
        win_q[i][K-1] <= colv[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) win_o[i*K+j] = win_q[i][j];
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution: line-buffered window, registered products, adder tree + bias + ReLU.
// Handshake: a beat transfers on a rising edge where valid && ready; the sender holds data until then.
module conv_stream_engine
  import npu_pkg::*;
#(
  parameter int unsigned K     = 3,
  parameter int unsigned IMG_W = 15,
  parameter int unsigned IMG_H = 16,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       relu_en,
  input  logic                       w_we,
  input  logic [$clog2(K*K+1)-1:0]   w_addr,
  input  logic [ACC_W-1:0]           w_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output state_e                     dbg_state
);

  localparam int unsigned NTAP = K * K;
  localparam int unsigned AW   = $clog2(K*K+1);
  localparam int unsigned PW   = 2 * DW + 1;
  localparam int unsigned CW   = $clog2(IMG_W);
  localparam int unsigned RW   = $clog2(IMG_H);
  localparam int unsigned OUTS = (IMG_H - K + 1) * (IMG_W - K + 1);
  localparam int unsigned OCW  = $clog2(OUTS + 1);

  if (ACC_W < acc_min_width(DW, K)) begin : g_acc_w_check
    $error("conv_stream_engine: ACC_W too narrow for exact K*K accumulation");
  end

  state_e                   state_q, state_d;
  logic [CW-1:0]            col_q;
  logic [RW-1:0]            row_q;
  logic [OCW-1:0]           out_cnt_q;
  logic                     relu_q;
  logic signed [DW-1:0]     w_q [NTAP];
  logic signed [ACC_W-1:0]  bias_q;
  logic [NTAP-1:0][DW-1:0]  win;
  logic                     win_vld_q, prod_vld_q;
  logic signed [PW-1:0]     prod_q [NTAP];
  logic signed [PW-1:0]     prod_d [NTAP];
  logic signed [ACC_W-1:0]  sum, res;
  logic                     out_valid_q, out_last_q;
  logic [ACC_W-1:0]         out_data_q;

  logic stall, advance, accept, last_pix, win_ok, pipe_empty;

  // Any unaccepted result freezes window, products and output together.
  assign stall      = out_valid_q && !out_ready;
  assign advance    = !stall;
  assign accept     = in_valid && in_ready;
  assign last_pix   = accept && (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
  assign win_ok     = (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));
  assign pipe_empty = !win_vld_q && !prod_vld_q && !out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_RUN;
      S_RUN:   if (last_pix)   state_d = S_DRAIN;
      S_DRAIN: if (pipe_empty) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_RUN) && !stall;
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done      = (state_q == S_DRAIN) && pipe_empty;
    dbg_state = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      relu_q    <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      col_q     <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      relu_q    <= relu_en;
    end else begin
      if (accept) begin
        if (col_q == CW'(IMG_W-1)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (advance && prod_vld_q) out_cnt_q <= out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) w_q[i] <= '0;
      bias_q <= '0;
    end else if (state_q == S_IDLE && w_we) begin
      for (int i = 0; i < NTAP; i++)
        if (w_addr == AW'(i)) w_q[i] <= w_data[DW-1:0];
      if (w_addr == AW'(NTAP)) bias_q <= w_data;
    end
  end

  window_line_buffer #(
    .K     (K),
    .IMG_W (IMG_W),
    .DW    (DW)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (accept),
    .col_i      (col_q),
    .pix_i      (in_data),
    .win_o      (win)
  );

  always_comb begin
    for (int i = 0; i < NTAP; i++)
      prod_d[i] = PW'($signed({1'b0, win[i]})) * PW'(w_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_vld_q  <= 1'b0;
      prod_vld_q <= 1'b0;
      for (int i = 0; i < NTAP; i++) prod_q[i] <= '0;
    end else if (advance) begin
      win_vld_q  <= accept && win_ok;
      prod_vld_q <= win_vld_q;
      if (win_vld_q)
        for (int i = 0; i < NTAP; i++) prod_q[i] <= prod_d[i];
    end
  end

  // ReLU is applied after the bias so a positive bias can lift small negative sums.
  always_comb begin
    sum = bias_q;
    for (int i = 0; i < NTAP; i++) sum = sum + ACC_W'(prod_q[i]);
    res = (relu_q && sum[ACC_W-1]) ? '0 : sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (advance) begin
      out_valid_q <= prod_vld_q;
      if (prod_vld_q) begin
        out_data_q <= res;
        out_last_q <= (out_cnt_q == OCW'(OUTS-1));
      end else begin
        out_last_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine: expected results queued at frame issue, checked by a monitor.
module tb_conv_stream_engine;

  localparam int K     = 3;
  localparam int IMG_W = 15;
  localparam int IMG_H = 16;
  localparam int DW    = 8;
  localparam int ACC_W = 24;
  localparam int AW    = $clog2(K*K+1);
  localparam int OH    = IMG_H - K + 1;
  localparam int OW    = IMG_W - K + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, relu_en = 1'b0, w_we = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [ACC_W-1:0] w_data = '0;
  logic in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic out_valid, out_ready = 1'b1;
  logic [ACC_W-1:0] out_data;
  logic out_last, busy, done;
  npu_pkg::state_e dbg_state;

  int ncmp = 0, nbad = 0, done_cnt = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic exp_last_q[$];
  int model_w[K*K];
  int model_b = 0;
  bit bp = 1'b0;
  bit prev_stall = 1'b0;
  logic [ACC_W-1:0] prev_data = '0;

  conv_stream_engine #(
    .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and downstream-ready generation
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] req);
    ncmp++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(req));
    end
  endtask

  task automatic timeout_fail(input string name);
    ncmp++;
    nbad++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic int pixv(input int mode, input int cval, input int r, input int c);
    return (mode == 0) ? cval : ((r * IMG_W + c) & 255);
  endfunction

  // Reference model: correlation of the frame with the current model weights.
  task automatic push_expected(input int mode, input int cval, input bit relu);
    int sum;
    for (int i = 0; i < OH; i++) begin
      for (int j = 0; j < OW; j++) begin
        sum = model_b;
        for (int a = 0; a < K; a++)
          for (int b = 0; b < K; b++)
            sum += model_w[a*K+b] * pixv(mode, cval, i + a, j + b);
        if (relu && sum < 0) sum = 0;
        exp_q.push_back(ACC_W'(sum));
        exp_last_q.push_back((i == OH - 1) && (j == OW - 1));
      end
    end
  endtask

  task automatic set_w(input int addr, input int val);
    w_we = 1'b1;
    w_addr = AW'(addr);
    w_data = ACC_W'(val);
    @(posedge clk);
    #1;
    w_we = 1'b0;
    if (addr < K*K) model_w[addr] = val;
    else model_b = val;
  endtask

  task automatic run_frame(input int mode, input int cval, input bit relu, input int abort_at,
                           input bit poke, input int ws_addr, input int ws_data);
    int d0, guard, r, c;
    if (ws_addr >= 0) begin
      w_we = 1'b1;
      w_addr = AW'(ws_addr);
      w_data = ACC_W'(ws_data);
      if (ws_addr < K*K) model_w[ws_addr] = ws_data;
      else model_b = ws_data;
    end
    push_expected(mode, cval, relu);
    d0 = done_cnt;
    relu_en = relu;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    w_we = 1'b0;
    relu_en = 1'b0;
    check("busy_in_run", ACC_W'(busy), ACC_W'(1));
    check("state_run", ACC_W'(dbg_state), ACC_W'(npu_pkg::S_RUN));
    for (int idx = 0; idx < IMG_H * IMG_W; idx++) begin
      r = idx / IMG_W;
      c = idx % IMG_W;
      if (bp && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data = DW'(pixv(mode, cval, r, c));
      if (poke && idx == 50) begin
        start = 1'b1;
        w_we = 1'b1;
        w_addr = '0;
        w_data = ACC_W'(77);
      end
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        timeout_fail("in_ready_wait");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      w_we = 1'b0;
      if (abort_at == idx + 1) begin
        rst = 1'b1;
        #1;
        check("rst_out_valid", ACC_W'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_last", ACC_W'(out_last), '0);
        check("rst_in_ready", ACC_W'(in_ready), '0);
        check("rst_busy", ACC_W'(busy), '0);
        check("rst_done", ACC_W'(done), '0);
        check("rst_state", ACC_W'(dbg_state), ACC_W'(npu_pkg::S_IDLE));
        exp_q.delete();
        exp_last_q.delete();
        in_valid = 1'b0;
        for (int i = 0; i < K*K; i++) model_w[i] = 0;
        model_b = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (done_cnt == d0 && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 5000) timeout_fail("done_wait");
    repeat (3) @(posedge clk);
    #1;
    check("done_once", ACC_W'(done_cnt), ACC_W'(d0 + 1));
    check("all_results_seen", ACC_W'(exp_q.size()), '0);
    check("busy_after_done", ACC_W'(busy), '0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_data_stable", out_data, prev_data);
      if (out_valid && !out_ready) begin
        check("in_ready_low_on_stall", ACC_W'(in_ready), '0);
        prev_stall = 1'b1;
        prev_data = out_data;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_output");
        end else begin
          check("out_data", out_data, exp_q.pop_front());
          check("out_last", ACC_W'(out_last), ACC_W'(exp_last_q.pop_front()));
        end
      end
      if (done) done_cnt++;
    end
  end

  // Stimulus
  initial begin
    for (int i = 0; i < K*K; i++) model_w[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", ACC_W'(in_ready), '0);
    check("reset_out_valid", ACC_W'(out_valid), '0);
    check("reset_out_last", ACC_W'(out_last), '0);
    check("reset_busy", ACC_W'(busy), '0);
    check("reset_done", ACC_W'(done), '0);
    check("reset_out_data", out_data, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < K*K; i++) set_w(i, 1);
    set_w(K*K, 0);
    run_frame(0, 1, 1'b0, 0, 1'b0, -1, 0);

    for (int i = 0; i < K*K; i++) set_w(i, (i == 4) ? 1 : 0);
    run_frame(1, 0, 1'b0, 0, 1'b0, -1, 0);

    for (int i = 0; i < K*K; i++) set_w(i, -128);
    run_frame(0, 255, 1'b0, 0, 1'b0, -1, 0);
    run_frame(0, 255, 1'b1, 0, 1'b0, -1, 0);

    for (int i = 0; i < K*K; i++) set_w(i, 1);
    set_w(K*K, 100);
    run_frame(0, 1, 1'b0, 0, 1'b0, -1, 0);

    set_w(K*K, 0);
    for (int i = 0; i < K*K; i++) set_w(i, (i == 4) ? 1 : 0);
    bp = 1'b1;
    run_frame(1, 0, 1'b0, 0, 1'b0, -1, 0);
    bp = 1'b0;

    run_frame(1, 0, 1'b0, 0, 1'b1, -1, 0);
    run_frame(1, 0, 1'b0, 0, 1'b0, -1, 0);
    run_frame(1, 0, 1'b0, 0, 1'b0, 4, 2);

    run_frame(1, 0, 1'b0, 100, 1'b0, -1, 0);
    for (int i = 0; i < K*K; i++) set_w(i, i - 4);
    set_w(K*K, -7);
    run_frame(1, 0, 1'b0, 0, 1'b0, -1, 0);

    $display("test done: total=%0d bad=%0d", ncmp, nbad);
    $finish;
  end

endmodule
